// File: rtl/pipelined_memory_pkg.sv
// Shared encodings for pipelined_memory: access sizes, FSM states, burst decode and default base.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BEAT  = 2'd2,
    WRESP = 2'd3
  } state_t;

  function automatic logic [3:0] BURST_BEATS(input logic [1:0] burst);
    case (burst)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_memory_if.sv
// Request/response bundle for pipelined_memory; req_burst exists only when MEM_BURST_EN is defined.
interface pipelined_memory_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic [31:0]           req_wdata;
`ifdef MEM_BURST_EN
  logic [1:0]            req_burst;
`endif
  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  resp_last;

`ifdef MEM_BURST_EN
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, req_burst,
    output req_ready, resp_valid, resp_data, resp_err, resp_last
  );
  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, req_burst,
    input  req_ready, resp_valid, resp_data, resp_err, resp_last
  );
`else
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err, resp_last
  );
  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err, resp_last
  );
`endif
endinterface

// File: rtl/pipelined_memory_lane_align.sv
// Combinational byte-lane steering: write enables/replicated write data, and right-aligned zero-extended reads.
// Zero latency, no handshake; misaligned/reserved combinations are filtered by the caller.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data,
  output logic [31:0] rd_data
);
  logic [31:0] rd_shift;

  always_comb begin
    wr_be    = 4'b0000;
    wr_data  = wdata;
    rd_data  = '0;
    rd_shift = rd_word >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: begin
        wr_be   = 4'b0001 << addr_lo;
        wr_data = {4{wdata[7:0]}};
        rd_data = {24'h0, rd_shift[7:0]};
      end
      SIZE_HALF: begin
        wr_be   = 4'b0011 << {addr_lo[1], 1'b0};
        wr_data = {2{wdata[15:0]}};
        rd_data = {16'h0, rd_shift[15:0]};
      end
      SIZE_WORD: begin
        wr_be   = 4'b1111;
        rd_data = rd_word;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pipelined_memory.sv
// Single-port memory: writes commit at accept with a response next cycle; reads return READ_LATENCY cycles after accept.
// Responses have no back-pressure; req_ready stays low from accept until the cycle after the last beat. MEM_BURST_EN enables read bursts.
module pipelined_memory
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    READ_LATENCY = 1
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_memory_if.slave bus
);
  localparam int                  IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);

  state_t                state, state_nxt;
  logic [31:0]           mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx_q, req_idx;
  logic [1:0]            lo_q, size_q, wait_cnt_q, lane_lo, lane_size;
  logic [3:0]            beats_q, req_beats, wr_be;
  logic                  err_q, req_err, accept, align_ok, range_ok, burst_ok;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH:0]   span_end;
  logic [31:0]           wr_data, rd_data, resp_data_q;
  logic                  resp_valid_q, resp_err_q, resp_last_q;

  assign bus.req_ready = (state == IDLE) && !resp_valid_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign offset        = bus.req_addr - BASE_ADDR;
  assign req_idx       = offset[IDX_W+1:2];

  // Writes are always single-beat; req_burst only shapes reads.
`ifdef MEM_BURST_EN
  assign req_beats = bus.req_write ? 4'd1 : BURST_BEATS(bus.req_burst);
`else
  assign req_beats = 4'd1;
`endif

  // Range is judged on the last beat, one bit wider so the sum cannot wrap.
  assign span_end = {1'b0, offset} + (ADDR_WIDTH+1)'({req_beats - 4'd1, 2'b00});
  assign range_ok = (bus.req_addr >= BASE_ADDR) && (span_end < LIMIT);
  assign burst_ok = (req_beats == 4'd1) || (bus.req_size == SIZE_WORD);
  assign req_err  = !(align_ok && range_ok && burst_ok);

  always_comb begin
    align_ok = 1'b0;
    case (bus.req_size)
      SIZE_BYTE: align_ok = 1'b1;
      SIZE_HALF: align_ok = !bus.req_addr[0];
      SIZE_WORD: align_ok = (bus.req_addr[1:0] == 2'b00);
      default:   align_ok = 1'b0;
    endcase
  end

  assign lane_lo   = (state == IDLE) ? bus.req_addr[1:0] : lo_q;
  assign lane_size = (state == IDLE) ? bus.req_size : size_q;

  mem_lane_align u_align (
    .addr_lo (lane_lo),
    .size    (lane_size),
    .wdata   (bus.req_wdata),
    .rd_word (mem[idx_q]),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_write)          state_nxt = WRESP;
          else if (READ_LATENCY > 1)  state_nxt = WAIT;
          else                        state_nxt = BEAT;
        end
      end
      WAIT:    if (wait_cnt_q == 2'(READ_LATENCY - 2)) state_nxt = BEAT;
      BEAT:    if (beats_q == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx_q        <= '0;
      lo_q         <= '0;
      size_q       <= '0;
      err_q        <= 1'b0;
      beats_q      <= 4'd1;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q      <= req_idx;
        lo_q       <= bus.req_addr[1:0];
        size_q     <= bus.req_size;
        err_q      <= req_err;
        beats_q    <= req_err ? 4'd1 : req_beats;
        wait_cnt_q <= '0;
      end else if (state == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 2'd1;
      end else if (state == BEAT) begin
        idx_q   <= idx_q + 1'b1;
        beats_q <= beats_q - 4'd1;
      end
      // Beats are registered, so each appears the cycle after its BEAT/WRESP cycle.
      resp_valid_q <= (state == BEAT) || (state == WRESP);
      resp_err_q   <= ((state == BEAT) || (state == WRESP)) && err_q;
      resp_last_q  <= (state == WRESP) || ((state == BEAT) && (beats_q == 4'd1));
      resp_data_q  <= ((state == BEAT) && !err_q) ? rd_data : 32'h0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_last  = resp_last_q;
  assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory: one instance at READ_LATENCY=1 and one at READ_LATENCY=3.
module tb_pipelined_memory;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid1 = 1'b0, req_valid3 = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = SIZE_WORD;
`ifdef MEM_BURST_EN
  logic [1:0]  req_burst = 2'b00;
`endif
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipelined_memory_if #(.ADDR_WIDTH(32)) bus1 ();
  pipelined_memory_if #(.ADDR_WIDTH(32)) bus3 ();

  assign bus1.req_valid = req_valid1;
  assign bus3.req_valid = req_valid3;
  assign bus1.req_write = req_write;
  assign bus3.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus3.req_addr  = req_addr;
  assign bus1.req_size  = req_size;
  assign bus3.req_size  = req_size;
  assign bus1.req_wdata = req_wdata;
  assign bus3.req_wdata = req_wdata;
`ifdef MEM_BURST_EN
  assign bus1.req_burst = req_burst;
  assign bus3.req_burst = req_burst;
`endif

  pipelined_memory #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .READ_LATENCY(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_memory #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .READ_LATENCY(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Single transaction on either instance; called #1 after a rising edge.
  task automatic do_req(input bit sel3, input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, output logic [31:0] data, output logic err,
                        output logic last, output int lat);
    int n;
    data = '0; err = 1'b0; last = 1'b0; lat = -1; n = 0;
    while (!(sel3 ? bus3.req_ready : bus1.req_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
`ifdef MEM_BURST_EN
    req_burst = 2'b00;
`endif
    if (sel3) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (sel3 ? bus3.resp_valid : bus1.resp_valid) begin
        data = sel3 ? bus3.resp_data : bus1.resp_data;
        err  = sel3 ? bus3.resp_err  : bus1.resp_err;
        last = sel3 ? bus3.resp_last : bus1.resp_last;
        lat  = c;
        break;
      end
    end
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout: no response for addr %h, required one within 20 cycles", addr);
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({bus1.resp_valid, bus1.resp_err, bus1.resp_last, bus1.resp_data} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b err=%b last=%b data=%h, required all 0",
               bus1.resp_valid, bus1.resp_err, bus1.resp_last, bus1.resp_data);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ready1=%b ready3=%b, required 1 1", bus1.req_ready, bus3.req_ready);
    end
  endtask

  task automatic test_word_half_byte;
    logic [31:0] d; logic e, l; int lat;
    do_req(0, 1, BASE, SIZE_WORD, 32'h9876_5432, d, e, l, lat);
    vectors++;
    if (d !== 32'h0 || e !== 1'b0 || l !== 1'b1 || lat !== 1) begin
      miscompares++;
      $display("FAIL wr_resp: data=%h err=%b last=%b lat=%0d, required 0 0 1 1", d, e, l, lat);
    end
    do_req(0, 0, BASE, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h9876_5432 || e !== 1'b0 || l !== 1'b1 || lat !== 1) begin
      miscompares++;
      $display("FAIL rd_word: data=%h err=%b last=%b lat=%0d, required 98765432 0 1 1", d, e, l, lat);
    end
    do_req(0, 0, BASE, SIZE_HALF, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h0000_5432 || e !== 1'b0) begin
      miscompares++; $display("FAIL rd_half: data=%h err=%b, required 00005432 0", d, e);
    end
    do_req(0, 0, BASE, SIZE_BYTE, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h0000_0032 || e !== 1'b0) begin
      miscompares++; $display("FAIL rd_byte: data=%h err=%b, required 00000032 0", d, e);
    end
    do_req(0, 0, BASE + 32'd2, SIZE_HALF, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h0000_9876 || e !== 1'b0) begin
      miscompares++; $display("FAIL rd_half_hi: data=%h err=%b, required 00009876 0", d, e);
    end
    do_req(0, 0, BASE + 32'd3, SIZE_BYTE, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h0000_0098 || e !== 1'b0) begin
      miscompares++; $display("FAIL rd_byte3: data=%h err=%b, required 00000098 0", d, e);
    end
  endtask

  task automatic test_partial_write;
    logic [31:0] d; logic e, l; int lat;
    do_req(0, 1, BASE + 32'h8, SIZE_WORD, 32'h1122_3344, d, e, l, lat);
    do_req(0, 1, BASE + 32'h8, SIZE_HALF, 32'h0000_AAAA, d, e, l, lat);
    do_req(0, 0, BASE + 32'h8, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h1122_AAAA) begin
      miscompares++; $display("FAIL half_merge: data=%h, required 1122aaaa", d);
    end
    do_req(0, 1, BASE + 32'hC, SIZE_WORD, 32'h0, d, e, l, lat);
    do_req(0, 1, BASE + 32'hD, SIZE_BYTE, 32'hFFFF_FFBB, d, e, l, lat);
    do_req(0, 0, BASE + 32'hC, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h0000_BB00) begin
      miscompares++; $display("FAIL byte_merge: data=%h, required 0000bb00", d);
    end
    do_req(0, 1, BASE + 32'hA, SIZE_HALF, 32'h0000_BEEF, d, e, l, lat);
    do_req(0, 0, BASE + 32'h8, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'hBEEF_AAAA) begin
      miscompares++; $display("FAIL upper_half: data=%h, required beefaaaa", d);
    end
  endtask

  task automatic test_errors;
    logic [31:0] d; logic e, l; int lat;
    logic        err_wr [5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] err_addr [5] = '{32'h8002_0001, 32'h8002_0002, 32'h8001_FFFC, 32'h8001_FFFC, 32'h8002_1000};
    logic [1:0]  err_size [5] = '{SIZE_HALF, SIZE_WORD, SIZE_WORD, SIZE_WORD, SIZE_WORD};
    for (int i = 0; i < 5; i++) begin
      do_req(0, err_wr[i], err_addr[i], err_size[i], 32'hFFFF_FFFF, d, e, l, lat);
      vectors++;
      if (e !== 1'b1 || d !== 32'h0 || l !== 1'b1 || lat !== 1) begin
        miscompares++;
        $display("FAIL err_case%0d: err=%b data=%h last=%b lat=%0d, required 1 0 1 1", i, e, d, l, lat);
      end
    end
    do_req(0, 1, BASE, SIZE_RSVD, 32'h0, d, e, l, lat);
    vectors++;
    if (e !== 1'b1 || d !== 32'h0) begin
      miscompares++; $display("FAIL err_rsvd: err=%b data=%h, required 1 0", e, d);
    end
    do_req(0, 0, BASE, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h9876_5432 || e !== 1'b0) begin
      miscompares++; $display("FAIL err_no_write: data=%h err=%b, required 98765432 0", d, e);
    end
    do_req(0, 1, BASE + 32'hFFC, SIZE_WORD, 32'hCAFE_F00D, d, e, l, lat);
    do_req(0, 0, BASE + 32'hFFC, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'hCAFE_F00D || e !== 1'b0) begin
      miscompares++; $display("FAIL last_word: data=%h err=%b, required cafef00d 0", d, e);
    end
  endtask

  task automatic test_latency3;
    logic [31:0] d; logic e, l; int lat; int n;
    do_req(1, 1, BASE, SIZE_WORD, 32'h1357_9BDF, d, e, l, lat);
    n = 0;
    while (!bus3.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_write = 1'b0; req_addr = BASE; req_size = SIZE_WORD; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus3.resp_valid !== (c == 3) || bus3.req_ready !== (c == 4)) begin
        miscompares++;
        $display("FAIL lat3_cycle%0d: valid=%b ready=%b, required %b %b",
                 c, bus3.resp_valid, bus3.req_ready, (c == 3), (c == 4));
      end
      if (c == 3) begin
        vectors++;
        if (bus3.resp_data !== 32'h1357_9BDF || bus3.resp_last !== 1'b1) begin
          miscompares++;
          $display("FAIL lat3_data: data=%h last=%b, required 13579bdf 1", bus3.resp_data, bus3.resp_last);
        end
      end
    end
  endtask

`ifdef MEM_BURST_EN
  task automatic test_burst;
    logic [31:0] d; logic e, l; int lat; int n;
    for (int i = 0; i < 4; i++)
      do_req(0, 1, BASE + 32'(4 * i), SIZE_WORD, 32'(i + 1), d, e, l, lat);
    n = 0;
    while (!bus1.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_write = 1'b0; req_addr = BASE; req_size = SIZE_WORD; req_burst = 2'b10; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    for (int b = 0; b < 5; b++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus1.resp_valid !== (b < 4) ||
          (b < 4 && (bus1.resp_data !== 32'(b + 1) || bus1.resp_last !== (b == 3) || bus1.resp_err !== 1'b0))) begin
        miscompares++;
        $display("FAIL burst4_beat%0d: valid=%b data=%h last=%b err=%b, required %b %0d %b 0",
                 b, bus1.resp_valid, bus1.resp_data, bus1.resp_last, bus1.resp_err, (b < 4), b + 1, (b == 3));
      end
    end
    req_addr = BASE + 32'hFF8; req_burst = 2'b11; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_burst = 2'b00;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus1.resp_valid !== (b == 0) ||
          (b == 0 && (bus1.resp_err !== 1'b1 || bus1.resp_last !== 1'b1 || bus1.resp_data !== 32'h0))) begin
        miscompares++;
        $display("FAIL burst8_err%0d: valid=%b err=%b last=%b data=%h, required %b 1 1 0",
                 b, bus1.resp_valid, bus1.resp_err, bus1.resp_last, bus1.resp_data, (b == 0));
      end
    end
  endtask
`endif

  task automatic test_reset_in_wait;
    logic [31:0] d; logic e, l; int lat; int n; int seen;
    n = 0; seen = 0;
    while (!bus3.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_write = 1'b0; req_addr = BASE; req_size = SIZE_WORD; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (bus3.resp_valid) seen++; end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (bus3.resp_valid) seen++; end
    vectors++;
    if (seen != 0 || bus3.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_abort: stray beats=%0d ready=%b, required 0 1", seen, bus3.req_ready);
    end
    do_req(1, 0, BASE, SIZE_WORD, 0, d, e, l, lat);
    vectors++;
    if (d !== 32'h1357_9BDF || e !== 1'b0 || lat !== 3) begin
      miscompares++;
      $display("FAIL rst_reread: data=%h err=%b lat=%0d, required 13579bdf 0 3", d, e, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word_half_byte();
    test_partial_write();
    test_errors();
    test_latency3();
`ifdef MEM_BURST_EN
    test_burst();
`endif
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
